// File: rtl/led_pkg.sv
// Shared constants for the LED controller: channel modes, LED drive levels,
// and an index-width helper that never returns less than one bit.
// No logic; no latency; no flow control.
package led_pkg;

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;
  localparam logic [1:0] MODE_PWM   = 2'b11;

  // LED pins sink current: driving low lights the LED.
  localparam logic LED_LIT  = 1'b0;
  localparam logic LED_DARK = 1'b1;

  // Width of an index or counter covering 0..n-1, at least one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Slow time base: prescaler tick plus a shared blink phase.
// Latency: tick is combinational from the prescaler state; blink_phase toggles on the edge after the last tick of a half-period.
// Backpressure: none, free-running.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   tick        one-cycle pulse while the prescaler sits at TICK_DIV-1
//   blink_phase 1 = blinking channels lit, 0 = dark; starts at 0
module led_tick_gen import led_pkg::*; #(
  parameter int TICK_DIV    = 50000,
  parameter int BLINK_TICKS = 250
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick,
  output logic blink_phase
);

  localparam int PW = idx_w(TICK_DIV);
  localparam int BW = idx_w(BLINK_TICKS);
  localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  logic [PW-1:0] pre_cnt;
  logic [BW-1:0] blink_cnt;

  // The tick coincides with the prescaler wrap cycle.
  assign tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt     <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (tick) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/led_ctrl.sv
// Multi-channel LED driver: per-channel OFF / ON / BLINK / PWM with registered active-low outputs.
// Latency: a write sampled at edge k is visible on LED after edge k+1.
// Backpressure: none; writes are accepted every cycle, writes to nonexistent channels are dropped.
//
// Ports:
//   CLK    system clock, rising edge
//   RST_N  asynchronous active-low reset (LED all dark, modes OFF, counters 0)
//   WE     one-cycle config write strobe
//   WCH    target channel index (ignored when >= NCH)
//   WMODE  00 OFF, 01 ON, 10 BLINK, 11 PWM
//   WDUTY  PWM duty; loaded together with the mode on every write
//   LED    registered LED drive, 0 = lit, 1 = dark
//
// Build option: define LED_CTRL_FADE_EN to make the effective PWM duty
// ramp one step per tick toward the duty register instead of jumping.
module led_ctrl import led_pkg::*; #(
  parameter int NCH         = 4,
  parameter int PWM_W       = 8,
  parameter int TICK_DIV    = 50000,
  parameter int BLINK_TICKS = 250
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   WE,
  input  logic [idx_w(NCH)-1:0]  WCH,
  input  logic [1:0]             WMODE,
  input  logic [PWM_W-1:0]       WDUTY,
  output logic [NCH-1:0]         LED
);

  localparam int CW = idx_w(NCH);

  logic [1:0]       mode_q   [NCH];
  logic [PWM_W-1:0] duty_q   [NCH];
  logic [PWM_W-1:0] eff_duty [NCH];
  logic [PWM_W-1:0] pwm_cnt;
  logic             tick;
  logic             blink_phase;
  logic [NCH-1:0]   led_nxt;

  led_tick_gen #(
    .TICK_DIV    (TICK_DIV),
    .BLINK_TICKS (BLINK_TICKS)
  ) u_tick (
    .clk         (CLK),
    .rst_n       (RST_N),
    .tick        (tick),
    .blink_phase (blink_phase)
  );

  // Config registers. Only indices that exist are compared, so a write
  // with WCH >= NCH matches nothing and leaves every register alone.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int ch = 0; ch < NCH; ch++) begin
        mode_q[ch] <= MODE_OFF;
        duty_q[ch] <= '0;
      end
    end else begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (WE && (WCH == CW'(ch))) begin
          mode_q[ch] <= WMODE;
          duty_q[ch] <= WDUTY;
        end
      end
    end
  end

  // Free-running PWM counter; natural wrap gives the 2^PWM_W period.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) pwm_cnt <= '0;
    else        pwm_cnt <= pwm_cnt + 1'b1;
  end

`ifdef LED_CTRL_FADE_EN
  logic [PWM_W-1:0] eff_q [NCH];

  // Fade one step per tick toward the target; outside PWM mode the
  // effective duty is parked at 0 so re-entering PWM fades up from dark.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int ch = 0; ch < NCH; ch++) eff_q[ch] <= '0;
    end else begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (mode_q[ch] != MODE_PWM) begin
          eff_q[ch] <= '0;
        end else if (tick) begin
          if (eff_q[ch] < duty_q[ch])      eff_q[ch] <= eff_q[ch] + 1'b1;
          else if (eff_q[ch] > duty_q[ch]) eff_q[ch] <= eff_q[ch] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int ch = 0; ch < NCH; ch++) eff_duty[ch] = eff_q[ch];
  end
`else
  // Without fading the tick has no consumer in this module.
  logic unused_tick;
  assign unused_tick = tick;

  always_comb begin
    for (int ch = 0; ch < NCH; ch++) eff_duty[ch] = duty_q[ch];
  end
`endif

  // Strict less-than: duty 0 never lights, full-scale duty stops one
  // count short of 100%.
  function automatic logic ch_lit(input logic [1:0]       m,
                                  input logic             ph,
                                  input logic [PWM_W-1:0] cnt,
                                  input logic [PWM_W-1:0] d);
    case (m)
      MODE_OFF:   return 1'b0;
      MODE_ON:    return 1'b1;
      MODE_BLINK: return ph;
      default:    return (cnt < d);
    endcase
  endfunction

  always_comb begin
    led_nxt = '1;
    for (int ch = 0; ch < NCH; ch++) begin
      led_nxt[ch] = ch_lit(mode_q[ch], blink_phase, pwm_cnt, eff_duty[ch]) ? LED_LIT : LED_DARK;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) LED <= '1;
    else        LED <= led_nxt;
  end

endmodule

// File: tb/tb_led_ctrl.sv
`timescale 1ns/1ps
module tb_led_ctrl;

  logic       CLK   = 1'b0;
  logic       RST_N = 1'b0;
  logic       WE    = 1'b0;
  logic [1:0] WCH   = 2'd0;
  logic [1:0] WMODE = 2'b00;
  logic [3:0] WDUTY = 4'd0;
  logic [3:0] led4;
  logic [2:0] led3;

  int checks = 0;
  int errors = 0;

  // Scoreboards: expected LED words queued when stimulus is driven.
  logic [3:0] exp4_q[$];
  logic [2:0] exp3_q[$];

  // Reference state for channel 1 PWM (state after the previous edge).
  logic m_pwm;
  int   m_duty;
  int   m_eff;

  led_ctrl #(.NCH(4), .PWM_W(4), .TICK_DIV(4), .BLINK_TICKS(2)) dut4 (
    .CLK(CLK), .RST_N(RST_N), .WE(WE), .WCH(WCH), .WMODE(WMODE), .WDUTY(WDUTY), .LED(led4)
  );

  led_ctrl #(.NCH(3), .PWM_W(4), .TICK_DIV(4), .BLINK_TICKS(2)) dut3 (
    .CLK(CLK), .RST_N(RST_N), .WE(WE), .WCH(WCH), .WMODE(WMODE), .WDUTY(WDUTY), .LED(led3)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Leaves the bench at a falling edge with reset just released, so the
  // next rising edge is edge 1 of a fresh run.
  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    WE    = 1'b0;
    m_pwm = 1'b0; m_duty = 0; m_eff = 0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  // Advance the channel-1 reference across edge n using the inputs
  // currently driven. Tick edges are n % 4 == 0 after a reset.
  task automatic model_edge(input int n);
`ifdef LED_CTRL_FADE_EN
    if (!m_pwm) m_eff = 0;
    else if (n % 4 == 0) begin
      if (m_eff < m_duty)      m_eff++;
      else if (m_eff > m_duty) m_eff--;
    end
`endif
    if (WE && WCH == 2'd1) begin
      m_pwm  = (WMODE == 2'b11);
      m_duty = int'(WDUTY);
    end
`ifndef LED_CTRL_FADE_EN
    m_eff = m_duty;
`endif
  endtask

  task automatic test_reset();
    logic [3:0] got;
    do_reset();
    WE = 1'b1; WCH = 2'd0; WMODE = 2'b01;
    @(posedge CLK); @(negedge CLK);
    WCH = 2'd2; WMODE = 2'b10;
    @(posedge CLK); @(negedge CLK);
    WE = 1'b0;
    repeat (21) @(negedge CLK);
    checks++;
    if (led4[0] !== 1'b0) begin
      errors++; $display("FAIL reset_pre_on got=%b exp=0", led4[0]);
    end
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if (led4 !== 4'b1111) begin
      errors++; $display("FAIL reset_async4 got=%b exp=1111", led4);
    end
    checks++;
    if (led3 !== 3'b111) begin
      errors++; $display("FAIL reset_async3 got=%b exp=111", led3);
    end
    // A write presented while reset is held must be lost.
    WE = 1'b1; WCH = 2'd2; WMODE = 2'b01;
    @(posedge CLK); @(negedge CLK);
    WE = 1'b0;
    RST_N = 1'b1;
    for (int c = 0; c < 20; c++) begin
      exp4_q.push_back(4'b1111);
      @(posedge CLK); #1;
      got = exp4_q.pop_front();
      checks++;
      if (led4 !== got) begin
        errors++; $display("FAIL reset_after cyc%0d got=%b exp=%b", c, led4, got);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_write_latency();
    logic [3:0] got;
    do_reset();
    for (int n = 1; n <= 6; n++) begin
      WE = (n == 1); WCH = 2'd2; WMODE = 2'b01; WDUTY = 4'd0;
      exp4_q.push_back((n == 1) ? 4'b1111 : 4'b1011);
      @(posedge CLK); #1;
      got = exp4_q.pop_front();
      checks++;
      if (led4 !== got) begin
        errors++; $display("FAIL write_latency edge%0d got=%b exp=%b", n, led4, got);
      end
      @(negedge CLK);
    end
    WE = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] got;
    logic [3:0] exp_tab [5];
    exp_tab = '{4'b1111, 4'b1110, 4'b1010, 4'b1110, 4'b1110};
    do_reset();
    for (int n = 1; n <= 5; n++) begin
      WE    = (n <= 3);
      WCH   = (n == 1) ? 2'd0 : 2'd2;
      WMODE = (n == 3) ? 2'b00 : 2'b01;
      exp4_q.push_back(exp_tab[n-1]);
      @(posedge CLK); #1;
      got = exp4_q.pop_front();
      checks++;
      if (led4 !== got) begin
        errors++; $display("FAIL back_to_back edge%0d got=%b exp=%b", n, led4, got);
      end
      @(negedge CLK);
    end
    WE = 1'b0;
  endtask

  task automatic test_blink();
    logic [3:0] got;
    logic       b;
    do_reset();
    for (int n = 1; n <= 40; n++) begin
      WE    = (n <= 2);
      WCH   = (n == 1) ? 2'd0 : 2'd3;
      WMODE = 2'b10;
      // Phase goes high at edge 8 and flips every 8 edges; LED follows one edge later.
      b = (n >= 2) && ((((n - 1) / 8) % 2) == 1);
      exp4_q.push_back({~b, 2'b11, ~b});
      @(posedge CLK); #1;
      got = exp4_q.pop_front();
      checks++;
      if (led4 !== got) begin
        errors++; $display("FAIL blink edge%0d got=%b exp=%b", n, led4, got);
      end
      @(negedge CLK);
    end
    WE = 1'b0;
  endtask

  task automatic test_pwm();
    logic [3:0] got;
    logic       lit;
    int         lit_cnt;
    int         n;
    int         dl [3];
    dl = '{4, 0, 15};
    n  = 0;
    do_reset();
    for (int s = 0; s < 3; s++) begin
      lit_cnt = 0;
      for (int c = 0; c < 96; c++) begin
        n++;
        WE = (c == 0); WCH = 2'd1; WMODE = 2'b11; WDUTY = 4'(dl[s]);
        lit = m_pwm && (((n - 1) % 16) < m_eff);
        exp4_q.push_back({2'b11, ~lit, 1'b1});
        model_edge(n);
        @(posedge CLK); #1;
        got = exp4_q.pop_front();
        checks++;
        if (led4 !== got) begin
          errors++; $display("FAIL pwm_d%0d edge%0d got=%b exp=%b", dl[s], n, led4, got);
        end
        if (c >= 80 && led4[1] == 1'b0) lit_cnt++;
        @(negedge CLK);
      end
      checks++;
      if (lit_cnt != dl[s]) begin
        errors++; $display("FAIL pwm_count_d%0d got=%0d exp=%0d", dl[s], lit_cnt, dl[s]);
      end
    end
    WE = 1'b0;
  endtask

  task automatic test_fade();
    logic [3:0] got;
    logic       lit;
    int         win [3];
    int         win_exp [3];
`ifdef LED_CTRL_FADE_EN
    win_exp = '{0, 1, 3};
`else
    win_exp = '{0, 3, 3};
`endif
    win = '{0, 0, 0};
    do_reset();
    for (int n = 1; n <= 48; n++) begin
      WE    = (n == 1) || (n == 13);
      WCH   = 2'd1;
      WMODE = 2'b11;
      WDUTY = (n == 13) ? 4'd3 : 4'd0;
      lit = m_pwm && (((n - 1) % 16) < m_eff);
      exp4_q.push_back({2'b11, ~lit, 1'b1});
      model_edge(n);
      @(posedge CLK); #1;
      got = exp4_q.pop_front();
      checks++;
      if (led4 !== got) begin
        errors++; $display("FAIL fade edge%0d got=%b exp=%b", n, led4, got);
      end
      if (led4[1] == 1'b0) win[(n - 1) / 16]++;
      @(negedge CLK);
    end
    WE = 1'b0;
    for (int w = 0; w < 3; w++) begin
      checks++;
      if (win[w] != win_exp[w]) begin
        errors++; $display("FAIL fade_window%0d got=%0d exp=%0d", w, win[w], win_exp[w]);
      end
    end
  endtask

  task automatic test_invalid_index();
    logic [3:0] got4;
    logic [2:0] got3;
    do_reset();
    for (int n = 1; n <= 10; n++) begin
      WE    = (n <= 4);
      WCH   = (n == 1) ? 2'd0 : (n == 2) ? 2'd2 : 2'd3;
      WMODE = (n == 3) ? 2'b00 : 2'b01;
      exp3_q.push_back((n >= 3) ? 3'b010 : (n == 2) ? 3'b110 : 3'b111);
      exp4_q.push_back((n >= 5) ? 4'b0010 : (n >= 3) ? 4'b1010 : (n == 2) ? 4'b1110 : 4'b1111);
      @(posedge CLK); #1;
      got3 = exp3_q.pop_front();
      got4 = exp4_q.pop_front();
      checks++;
      if (led3 !== got3) begin
        errors++; $display("FAIL invalid_idx_nch3 edge%0d got=%b exp=%b", n, led3, got3);
      end
      checks++;
      if (led4 !== got4) begin
        errors++; $display("FAIL valid_idx3_nch4 edge%0d got=%b exp=%b", n, led4, got4);
      end
      @(negedge CLK);
    end
    WE = 1'b0;
  endtask

  initial begin
    m_pwm = 1'b0; m_duty = 0; m_eff = 0;
    test_reset();
    test_write_latency();
    test_back_to_back();
    test_blink();
    test_pwm();
    test_fade();
    test_invalid_index();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_ctrl.md
LED_CTRL -- requirements
Module: led_ctrl

Interface
REQ-001 SHALL have parameter NCH, default 4, number of LED channels (1..16).
REQ-002 SHALL have parameter PWM_W, default 8, duty/PWM counter width.
REQ-003 SHALL have parameter TICK_DIV, default 50000, CLK cycles per tick (>=2).
REQ-004 SHALL have parameter BLINK_TICKS, default 250, ticks per blink half-period (>=1).
REQ-005 SHALL have port CLK  in  1  single system clock; all state on rising edge.
REQ-006 SHALL have port RST_N  in  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port WE  in  1  one-cycle config write strobe.
REQ-008 SHALL have port WCH  in  clog2(NCH) (min 1)  target channel index.
REQ-009 SHALL have port WMODE  in  2  mode: 00 OFF, 01 ON, 10 BLINK, 11 PWM.
REQ-010 SHALL have port WDUTY  in  PWM_W  PWM duty, used in PWM mode.
REQ-011 SHALL have port LED  out  NCH  registered LED drive, active-low (0 = lit, 1 = dark).

Function
REQ-012 SHALL hold per-channel mode[1:0] and duty[PWM_W-1:0] registers, loaded on the rising edge where WE=1 and WCH<NCH.
REQ-013 SHALL ignore writes with WCH>=NCH; no register changes.
REQ-014 SHALL load mode and duty together on each write, whatever WMODE is.
REQ-015 SHALL have a prescaler counting 0..TICK_DIV-1, wrapping to 0, with a one-cycle tick pulse on the wrap cycle.
REQ-016 SHALL have a blink counter advancing on tick, 0..BLINK_TICKS-1, toggling a shared blink_phase on wrap; blink_phase=1 means lit.
REQ-017 SHALL have a free-running PWM counter of PWM_W bits incrementing every CLK and wrapping 2^PWM_W-1 -> 0.
REQ-018 SHALL light a channel as: OFF never; ON always; BLINK when blink_phase=1; PWM when pwm_cnt < effective duty.
REQ-019 SHALL keep duty 0 dark always and never reach 100% with PWM, maximum duty giving (2^PWM_W-1)/2^PWM_W lit.
REQ-020 SHALL register LED from mode/duty/counter state: a write sampled at edge k shows on LED after edge k+1.
REQ-021 SHALL share blink_phase across all channels so BLINK channels stay in phase; a write does not reset the counters.

Reset
REQ-022 SHALL, while RST_N=0, force LED to all 1 (all dark), modes to OFF, duties to 0, all counters to 0 and blink_phase to 0.
REQ-023 SHALL take effect asynchronously, even mid-blink or mid-fade; a WE present during reset is lost.
REQ-024 SHALL resume counting from 0 on the first rising edge after RST_N deasserts.

Configuration
REQ-025 SHALL use macro LED_CTRL_FADE_EN: when defined, each channel's effective duty steps by 1 toward its duty register on each tick, only in PWM mode.
REQ-026 SHALL, with LED_CTRL_FADE_EN defined, hold effective duty on reset at 0 and set it directly to 0 when leaving PWM mode.
REQ-027 SHALL, with LED_CTRL_FADE_EN undefined, make effective duty equal the duty register immediately, with no extra state.

Structure
REQ-028 SHALL put in package led_pkg: mode constants MODE_OFF/ON/BLINK/PWM, LED_LIT=1'b0, LED_DARK=1'b1.
REQ-029 SHALL place prescaler and blink counter in sub-module led_tick_gen (outputs tick, blink_phase); all else stays in led_ctrl.

Verification (bench uses NCH=4, PWM_W=4, TICK_DIV=4, BLINK_TICKS=2)
REQ-030 SHALL check reset: RST_N low mid-operation -> LED=4'b1111 at once, all modes OFF after release.
REQ-031 SHALL check write latency: WE, WCH=2, WMODE=01 at edge k -> LED[2]=0 after edge k+1, other bits stay 1.
REQ-032 SHALL check blink: ch0 BLINK after reset -> LED[0] dark for the first 8 cycles, then toggles every 8 cycles, in phase with ch3 BLINK.
REQ-033 SHALL check PWM: ch1 PWM duty=4 -> LED[1] lit 4 of every 16 cycles; duty=0 -> never lit; duty=15 -> lit 15 of 16.
REQ-034 SHALL check an invalid index with a 2-bit WCH, run with NCH=3: WE with WCH=3 -> no state change, LED unchanged.
REQ-035 SHALL check LED_CTRL_FADE_EN: PWM duty 0->3 -> effective duty 1,2,3 on three successive ticks, lit count per 16 cycles rising to match.
